// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-lane round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        GRANT
    } arb_state_t;

    // One-hot lane decode used for the grant vector.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting lane after ptr, wrapping to ptr itself.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] win
);

    lane_idx_t idx;

    // Scan ptr+1, ptr+2, ptr+3, ptr and keep the first hit.
    always_comb begin
        any = 1'b0;
        win = ptr;
        idx = ptr;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = ptr + lane_idx_t'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin sequencer for a shared 4:1 mux with a select turnaround guard.
// Optional macro MUX4_ARB_LOCK_EN adds a lock input that suppresses the MAX_HOLD release.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       dout,
    output logic       dout_vld,
    output logic       busy
`ifdef MUX4_ARB_LOCK_EN
    ,
    input  logic       lock
`endif
);

    localparam logic [2:0] TurnLast = 3'((TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1);
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    arb_state_t state_q, state_d;
    lane_idx_t  sel_q, sel_d;
    lane_idx_t  ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] turn_q, turn_d;
    logic       dout_q;
    logic       dout_vld_q;

    logic       lock_act;
    logic       pick_any;
    lane_idx_t  pick_win;
    lane_idx_t  pick_ptr;
    logic       release_now;

`ifdef MUX4_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // On a release the pointer is about to become sel, so pick against sel directly.
    assign pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .win (pick_win)
    );

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= 2'd3;
            hold_q     <= '0;
            turn_q     <= '0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            if (state_q == GRANT) begin
                dout_q     <= din[sel_q];
                dout_vld_q <= 1'b1;
            end else begin
                dout_vld_q <= 1'b0;
            end
        end
    end

    // Next-state logic: pick on IDLE, guard in TURN, tenure limit and re-pick in GRANT.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        release_now = !req[sel_q] || ((hold_q == HoldLast) && !lock_act);
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_win;
                    turn_d  = '0;
                    hold_d  = '0;
                    state_d = (TURN_CYCLES == 0) ? GRANT : TURN;
                end
            end
            TURN: begin
                turn_d = turn_q + 3'd1;
                if (!req[sel_q]) begin
                    state_d = IDLE;
                end else if (turn_q == TurnLast) begin
                    state_d = GRANT;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = sel_q;
                    hold_d = '0;
                    if (!pick_any) begin
                        state_d = IDLE;
                    end else if (pick_win != sel_q) begin
                        sel_d   = pick_win;
                        turn_d  = '0;
                        state_d = (TURN_CYCLES == 0) ? GRANT : TURN;
                    end
                    // Sole requester keeps the select, so no turnaround is needed.
                end else begin
                    // Saturate only matters while lock holds the tenure open.
                    hold_d = (hold_q == HoldLast) ? hold_q : hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant only in GRANT, busy whenever the mux is claimed.
    always_comb begin
        gnt      = (state_q == GRANT) ? lane_onehot(sel_q) : 4'b0000;
        busy     = (state_q != IDLE);
        sel      = sel_q;
        dout     = dout_q;
        dout_vld = dout_vld_q;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter with TURN_CYCLES=1, MAX_HOLD=4.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       dout;
    logic       dout_vld;
    logic       busy;

    int         checks;
    int         errors;
    logic [3:0] exp_q[$];

    mux4_rr_arbiter #(
        .TURN_CYCLES (1),
        .MAX_HOLD    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .sel      (sel),
        .gnt      (gnt),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy)
`ifdef MUX4_ARB_LOCK_EN
        ,
        .lock     (1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(g);
    endtask

    // Data lanes keep changing so dout tracks real per-cycle values.
    initial begin
        din = 4'b1011;
        forever begin
            @(posedge clk);
            #1;
            din = din + 4'd5;
        end
    end

    // Monitor: pops an expected grant for every granted cycle, checks dout one cycle later.
    initial begin
        logic       dpend;
        logic       dexp;
        logic [3:0] e;
        int         li;
        dpend = 1'b0;
        dexp  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dpend = 1'b0;
            end else begin
                if (dpend) begin
                    chk("dout_vld_after_grant", {7'd0, dout_vld}, 8'd1);
                    chk("dout_value", {7'd0, dout}, {7'd0, dexp});
                end else begin
                    chk("dout_vld_idle", {7'd0, dout_vld}, 8'd0);
                end
                dpend = 1'b0;
                if (gnt != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", {4'd0, gnt}, 8'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        chk("grant", {4'd0, gnt}, {4'd0, e});
                        li = 0;
                        for (int k = 0; k < 4; k++) if (e[k]) li = k;
                        dexp  = din[li];
                        dpend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b1111;

        // Reset with all lanes requesting.
        tick(2);
        chk("rst_sel", {6'd0, sel}, 8'd0);
        chk("rst_gnt", {4'd0, gnt}, 8'd0);
        chk("rst_dout_vld", {7'd0, dout_vld}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);

        // Rotation 0,1,2,3,0 with four-cycle tenures.
        push(4'b0001, 4);
        push(4'b0010, 4);
        push(4'b0100, 4);
        push(4'b1000, 4);
        push(4'b0001, 4);
        rst_n = 1'b1;
        tick(1);
        chk("rot_turn_sel", {6'd0, sel}, 8'd0);
        chk("rot_turn_gnt", {4'd0, gnt}, 8'd0);
        tick(1);
        chk("rot_first_gnt", {4'd0, gnt}, 8'h01);
        tick(4);
        chk("rot_gap_gnt", {4'd0, gnt}, 8'd0);
        chk("rot_gap_busy", {7'd0, busy}, 8'd1);
        chk("rot_gap_sel", {6'd0, sel}, 8'd1);
        tick(19);
        req = 4'b0000;
        tick(1);
        chk("rot_end_busy", {7'd0, busy}, 8'd0);
        chk("rot_queue_empty", 8'(exp_q.size()), 8'd0);

        // Single requester: continuous grant across hold expiries.
        req = 4'b0100;
        push(4'b0100, 9);
        tick(1);
        chk("single_sel", {6'd0, sel}, 8'd2);
        chk("single_turn_gnt", {4'd0, gnt}, 8'd0);
        chk("single_turn_busy", {7'd0, busy}, 8'd1);
        tick(5);
        chk("single_expiry_gnt", {4'd0, gnt}, 8'h04);
        tick(4);
        req = 4'b0000;
        tick(1);
        chk("single_end_busy", {7'd0, busy}, 8'd0);
        chk("single_queue_empty", 8'(exp_q.size()), 8'd0);

        // Early release of lane 1 with lanes 3 and 0 waiting.
        req = 4'b0010;
        push(4'b0010, 2);
        push(4'b1000, 4);
        push(4'b0001, 4);
        tick(3);
        chk("early_gnt1", {4'd0, gnt}, 8'h02);
        req = 4'b1001;
        tick(1);
        chk("early_next_sel", {6'd0, sel}, 8'd3);
        chk("early_turn_gnt", {4'd0, gnt}, 8'd0);
        tick(9);
        req = 4'b0000;
        tick(1);
        chk("early_end_busy", {7'd0, busy}, 8'd0);
        chk("early_queue_empty", 8'(exp_q.size()), 8'd0);

        // Abort in TURN, pointer unchanged afterwards.
        req = 4'b0010;
        tick(1);
        chk("abort_sel", {6'd0, sel}, 8'd1);
        chk("abort_busy", {7'd0, busy}, 8'd1);
        req = 4'b0000;
        tick(1);
        chk("abort_idle_busy", {7'd0, busy}, 8'd0);
        chk("abort_idle_gnt", {4'd0, gnt}, 8'd0);
        req = 4'b0011;
        push(4'b0010, 4);
        push(4'b0001, 4);
        tick(10);
        req = 4'b0000;
        tick(1);
        chk("abort_end_busy", {7'd0, busy}, 8'd0);
        chk("abort_queue_empty", 8'(exp_q.size()), 8'd0);

        // Asynchronous reset in the middle of a lane-3 grant.
        req = 4'b1000;
        push(4'b1000, 1);
        tick(2);
        chk("areset_pre_gnt", {4'd0, gnt}, 8'h08);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_gnt", {4'd0, gnt}, 8'd0);
        chk("areset_busy", {7'd0, busy}, 8'd0);
        chk("areset_sel", {6'd0, sel}, 8'd0);
        chk("areset_dout_vld", {7'd0, dout_vld}, 8'd0);
        req = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("final_busy", {7'd0, busy}, 8'd0);
        chk("final_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
